// File: rtl/move_scan.sv
// Diagonal legal-move scanner: walks UL, UR, DL, DR one per cycle and accumulates simple-move and capture source masks.
// Results are registered and held until the next scan completes; start is ignored while a scan is running.
module move_scan #(
  parameter int NDIR = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        side,
  input  logic [31:0] own,
  input  logic [31:0] opp,
  input  logic [31:0] kings,
  output logic        busy,
  output logic        done,
  output logic [31:0] move_src,
  output logic [31:0] jump_src,
  output logic [31:0] legal_src,
  output logic        must_jump,
  output logic        no_moves
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  localparam logic [1:0] LAST_DIR = 2'(NDIR - 1);

  state_t      state_q, state_d;
  logic [1:0]  dir_q, dir_d;
  logic        side_q;
  logic [31:0] own_q, opp_q, kings_q;
  logic [31:0] acc_mv_q, acc_mv_d;
  logic [31:0] acc_jp_q, acc_jp_d;
  logic [31:0] move_src_q, jump_src_q, legal_src_q;
  logic        must_jump_q, no_moves_q, done_q;

  logic [31:0] occ, movers, s1_occ, s1_opp, s2_occ, mv_dir, jp_dir;

  // Off-board neighbours read as occupied, which blocks border moves and jumps for free.
  function automatic logic [31:0] shift_dir(input logic [1:0] d, input logic [31:0] x);
    logic [31:0] s;
    logic [4:0]  idx;
    logic [2:0]  row;
    logic [1:0]  col;
    s = '1;
    for (int i = 0; i < 32; i++) begin
      idx = 5'(i);
      row = idx[4:2];
      col = idx[1:0];
      case (d)
        2'd0:    if (col <= 2'd2 && row <= 3'd6) s[i] = x[idx + 5'd4];
        2'd1:    if (col >= 2'd1 && row <= 3'd6) s[i] = x[idx + 5'd3];
        2'd2:    if (col <= 2'd2 && row >= 3'd1) s[i] = x[idx - 5'd3];
        default: if (col >= 2'd1 && row >= 3'd1) s[i] = x[idx - 5'd4];
      endcase
    end
    return s;
  endfunction

  always_comb begin
    occ    = own_q | opp_q;
    // Men of side 0 move in dirs 0/1 (UL/UR), side 1 in dirs 2/3 (DL/DR); kings move everywhere.
    movers = (own_q & kings_q) | ((dir_q[1] == side_q) ? (own_q & ~kings_q) : 32'd0);
    s1_occ = shift_dir(dir_q, occ);
    s1_opp = shift_dir(dir_q, opp_q);
    s2_occ = shift_dir(dir_q, s1_occ);
    mv_dir = movers & ~s1_occ;
    jp_dir = movers & s1_opp & ~s2_occ;
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    acc_mv_d = acc_mv_q;
    acc_jp_d = acc_jp_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SCAN;
          dir_d    = 2'd0;
          acc_mv_d = 32'd0;
          acc_jp_d = 32'd0;
        end
      end
      S_SCAN: begin
        acc_mv_d = acc_mv_q | mv_dir;
        acc_jp_d = acc_jp_q | jp_dir;
        dir_d    = dir_q + 2'd1;
        if (dir_q == LAST_DIR) begin
          state_d = S_DONE;
          dir_d   = 2'd0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dir_q       <= 2'd0;
      acc_mv_q    <= 32'd0;
      acc_jp_q    <= 32'd0;
      side_q      <= 1'b0;
      own_q       <= 32'd0;
      opp_q       <= 32'd0;
      kings_q     <= 32'd0;
      move_src_q  <= 32'd0;
      jump_src_q  <= 32'd0;
      legal_src_q <= 32'd0;
      must_jump_q <= 1'b0;
      no_moves_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      acc_mv_q <= acc_mv_d;
      acc_jp_q <= acc_jp_d;
      done_q   <= 1'b0;
      if (state_q == S_IDLE && start) begin
        side_q  <= side;
        own_q   <= own;
        opp_q   <= opp;
        kings_q <= kings;
      end
      if (state_q == S_DONE) begin
        move_src_q  <= acc_mv_q;
        jump_src_q  <= acc_jp_q;
        legal_src_q <= (|acc_jp_q) ? acc_jp_q : acc_mv_q;
        must_jump_q <= |acc_jp_q;
        no_moves_q  <= (acc_mv_q == 32'd0) && (acc_jp_q == 32'd0);
        done_q      <= 1'b1;
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign move_src  = move_src_q;
  assign jump_src  = jump_src_q;
  assign legal_src = legal_src_q;
  assign must_jump = must_jump_q;
  assign no_moves  = no_moves_q;

endmodule

// File: tb/tb_move_scan.sv
// Directed bench for move_scan: square-by-square reference model plus hand-computed literal checks.
module tb_move_scan;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        side  = 1'b0;
  logic [31:0] own   = 32'd0;
  logic [31:0] opp   = 32'd0;
  logic [31:0] kings = 32'd0;
  logic        busy, done, must_jump, no_moves;
  logic [31:0] move_src, jump_src, legal_src;

  int vecs = 0;
  int miss = 0;
  bit chk_en = 1'b0;

  move_scan #(.NDIR(4)) dut (
    .clock(clock), .reset(reset), .start(start), .side(side),
    .own(own), .opp(opp), .kings(kings),
    .busy(busy), .done(done), .move_src(move_src), .jump_src(jump_src),
    .legal_src(legal_src), .must_jump(must_jump), .no_moves(no_moves)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Neighbour of square i in direction d by board coordinates; -1 if off-board.
  function automatic int nbr(input int d, input int i);
    int r, c;
    if (i < 0) return -1;
    r = i / 4;
    c = i % 4;
    case (d)
      0:       return (c <= 2 && r <= 6) ? (r + 1) * 4 + c     : -1;
      1:       return (c >= 1 && r <= 6) ? (r + 1) * 4 + c - 1 : -1;
      2:       return (c <= 2 && r >= 1) ? (r - 1) * 4 + c + 1 : -1;
      default: return (c >= 1 && r >= 1) ? (r - 1) * 4 + c     : -1;
    endcase
  endfunction

  function automatic bit at(input logic [31:0] m, input int j);
    return (j < 0) ? 1'b1 : m[j];
  endfunction

  task automatic model(input logic s, input logic [31:0] o, input logic [31:0] p,
                       input logic [31:0] k, output logic [31:0] mv, output logic [31:0] jp);
    logic [31:0] oc;
    int n1, n2;
    oc = o | p;
    mv = '0;
    jp = '0;
    for (int i = 0; i < 32; i++) begin
      if (o[i]) begin
        for (int d = 0; d < 4; d++) begin
          if (k[i] || ((d / 2) == int'(s))) begin
            n1 = nbr(d, i);
            n2 = nbr(d, n1);
            if (!at(oc, n1)) mv[i] = 1'b1;
            if (at(p, n1) && !at(oc, n2)) jp[i] = 1'b1;
          end
        end
      end
    end
  endtask

  int          m_cnt = 0;
  logic [31:0] p_mv = '0, p_jp = '0;
  logic [31:0] e_mv = '0, e_jp = '0, e_legal = '0;
  logic        e_done = 1'b0, e_mj = 1'b0, e_nm = 1'b0;

  // Timeline model: start accepted only when idle, results due five edges later.
  always @(posedge clock) begin
    if (reset) begin
      m_cnt = 0; e_done = 0; e_mv = '0; e_jp = '0; e_legal = '0; e_mj = 0; e_nm = 0;
    end else begin
      e_done = 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          model(side, own, opp, kings, p_mv, p_jp);
          m_cnt = 1;
        end
      end else if (m_cnt == 5) begin
        m_cnt   = 0;
        e_done  = 1'b1;
        e_mv    = p_mv;
        e_jp    = p_jp;
        e_mj    = |p_jp;
        e_legal = e_mj ? p_jp : p_mv;
        e_nm    = (p_mv == 0) && (p_jp == 0);
      end else begin
        m_cnt++;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_cnt != 0));
      chk("done", 32'(done), 32'(e_done));
      chk("move_src", move_src, e_mv);
      chk("jump_src", jump_src, e_jp);
      chk("legal_src", legal_src, e_legal);
      chk("must_jump", 32'(must_jump), 32'(e_mj));
      chk("no_moves", 32'(no_moves), 32'(e_nm));
    end
  end

  task automatic run_scan(input logic s, input logic [31:0] o, input logic [31:0] p, input logic [31:0] k);
    int n;
    bit got;
    @(negedge clock);
    side = s; own = o; opp = p; kings = k; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    n = 0;
    got = 0;
    while (!got && n < 20) begin
      @(posedge clock);
      n++;
      #1 if (done) got = 1;
    end
    chk("done_latency", 32'(n), 32'd5);
  endtask

  task automatic chk_res(input string nm, input logic [31:0] mv, input logic [31:0] jp,
                         input logic [31:0] lg, input logic mj, input logic nmv);
    chk({nm, "_move"}, move_src, mv);
    chk({nm, "_jump"}, jump_src, jp);
    chk({nm, "_legal"}, legal_src, lg);
    chk({nm, "_mj"}, 32'(must_jump), 32'(mj));
    chk({nm, "_nomv"}, 32'(no_moves), 32'(nmv));
  endtask

  initial begin
    int dcount;
    @(posedge clock);
    #1 chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_move", move_src, 32'd0);
    chk("rst_nomv", 32'(no_moves), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    run_scan(1'b0, 32'h0000_0100, 32'h0, 32'h0);
    chk_res("man8", 32'h0000_0100, 32'h0, 32'h0000_0100, 1'b0, 1'b0);

    run_scan(1'b0, 32'h0000_0100, 32'h0000_1000, 32'h0);
    chk_res("jump8", 32'h0, 32'h0000_0100, 32'h0000_0100, 1'b1, 1'b0);

    run_scan(1'b0, 32'h1000_0000, 32'h0, 32'h0);
    chk_res("edge28", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

    run_scan(1'b0, 32'h1000_0000, 32'h0, 32'h1000_0000);
    chk_res("king28", 32'h1000_0000, 32'h0, 32'h1000_0000, 1'b0, 1'b0);

    run_scan(1'b1, 32'h0000_0100, 32'h0, 32'h0);
    chk_res("side1", 32'h0000_0100, 32'h0, 32'h0000_0100, 1'b0, 1'b0);

    run_scan(1'b0, 32'h0000_0200, 32'h0, 32'h0);
    chk_res("man9", 32'h0000_0200, 32'h0, 32'h0000_0200, 1'b0, 1'b0);

    run_scan(1'b0, 32'h0000_0300, 32'h0000_1000, 32'h0);
    chk_res("mixed", 32'h0000_0200, 32'h0000_0100, 32'h0000_0100, 1'b1, 1'b0);

    // Start while busy with different inputs: must be ignored.
    @(negedge clock);
    side = 1'b0; own = 32'h0000_0100; opp = 32'h0000_1000; kings = 32'h0; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    #1 begin own = 32'h0000_0200; opp = 32'h0; start = 1'b1; end
    @(posedge clock);
    #1 start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      #1 if (done) dcount++;
    end
    chk("busy_done_count", 32'(dcount), 32'd1);
    chk_res("busy_ign", 32'h0, 32'h0000_0100, 32'h0000_0100, 1'b1, 1'b0);

    // Reset during the second scan cycle.
    @(negedge clock);
    side = 1'b1; own = 32'h0000_0100; opp = 32'h0; kings = 32'h0; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 begin
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk_res("mid_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      reset = 1'b0;
    end
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1 if (done) dcount++;
    end
    chk("rst_no_done", 32'(dcount), 32'd0);

    run_scan(1'b1, 32'h0000_0100, 32'h0, 32'h0);
    chk_res("post_rst", 32'h0000_0100, 32'h0, 32'h0000_0100, 1'b0, 1'b0);

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
